// File: rtl/mxv_resp_framer_pkg.sv
// Shared definitions for the MxV UART response path: frame delimiters, command codes,
// byte type and framer state encoding (CSUM exists only with MXV_FRAME_CHECKSUM_EN).
package mxv_resp_framer_pkg;

    localparam logic [7:0] FRAME_SOF = 8'hFE;
    localparam logic [7:0] FRAME_EOF = 8'hEF;

    localparam logic [7:0] CMD_LOAD_MATRIX = 8'h01;
    localparam logic [7:0] CMD_LOAD_VECTOR = 8'h02;
    localparam logic [7:0] CMD_MULTIPLY    = 8'h03;
    localparam logic [7:0] CMD_READ_RESULT = 8'h04;

    typedef logic [7:0] word_lenght_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF,
        ST_LEN,
        ST_CMD,
        ST_FETCH,
        ST_DATA,
`ifdef MXV_FRAME_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_EOF,
        ST_FIN
    } framer_state_t;

    // States that put one byte on the UART: an issue cycle followed by a wait for tx_done.
    function automatic logic is_byte_state(input framer_state_t s);
        case (s)
            ST_SOF, ST_LEN, ST_CMD, ST_DATA,
`ifdef MXV_FRAME_CHECKSUM_EN
            ST_CSUM,
`endif
            ST_EOF:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mxv_resp_framer.sv
// Response-frame transmitter: FE, LEN, CMD, payload from the result buffer, EF.
// Define MXV_FRAME_CHECKSUM_EN to insert an XOR checksum byte (LEN^CMD^payload) before EF.
module mxv_resp_framer
    import mxv_resp_framer_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    cmd,
    input  logic [AW:0]   len,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_done,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0] MAX_CNT = (AW+1)'(MAX_LEN);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

`ifdef MXV_FRAME_CHECKSUM_EN
    localparam framer_state_t POST_PAYLOAD = ST_CSUM;
`else
    localparam framer_state_t POST_PAYLOAD = ST_EOF;
`endif

    framer_state_t state_q;
    framer_state_t state_d;

    logic          waiting_q;
    word_lenght_t  cmd_q;
    word_lenght_t  data_q;
    logic [AW:0]   count_q;
    logic [AW:0]   idx_q;
    logic [AW:0]   idx_inc;
    logic [AW:0]   len_clamped;
    word_lenght_t  len_byte;
    logic          issue;
    logic          advance;
    logic          start_accept;

`ifdef MXV_FRAME_CHECKSUM_EN
    word_lenght_t  csum_q;
`endif

    // A new frame may be accepted in FIN as well, so back-to-back frames lose no cycle.
    assign start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_FIN));
    assign issue        = is_byte_state(state_q) && !waiting_q;
    assign advance      = is_byte_state(state_q) && waiting_q && tx_done;
    assign idx_inc      = idx_q + CNT_ONE;
    assign len_clamped  = (len > MAX_CNT) ? MAX_CNT : len;
    assign len_byte     = word_lenght_t'(count_q) + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_accept) state_d = ST_SOF;
            ST_FIN:   state_d = start_accept ? ST_SOF : ST_IDLE;
            ST_SOF:   if (advance) state_d = ST_LEN;
            ST_LEN:   if (advance) state_d = ST_CMD;
            ST_CMD:   if (advance) state_d = (count_q == '0) ? POST_PAYLOAD : ST_FETCH;
            ST_FETCH: state_d = ST_DATA;
            ST_DATA:  if (advance) state_d = (idx_inc == count_q) ? POST_PAYLOAD : ST_FETCH;
`ifdef MXV_FRAME_CHECKSUM_EN
            ST_CSUM:  if (advance) state_d = ST_EOF;
`endif
            ST_EOF:   if (advance) state_d = ST_FIN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // rd_data is only valid in the DATA issue cycle, so it is captured there for the wait phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            waiting_q <= 1'b0;
            cmd_q     <= '0;
            data_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
        end else begin
            if (issue) begin
                waiting_q <= 1'b1;
            end else if (advance) begin
                waiting_q <= 1'b0;
            end
            if (start_accept) begin
                cmd_q   <= cmd;
                count_q <= len_clamped;
                idx_q   <= '0;
            end
            if ((state_q == ST_DATA) && issue) begin
                data_q <= rd_data;
            end
            if ((state_q == ST_DATA) && advance) begin
                idx_q <= idx_inc;
            end
        end
    end

`ifdef MXV_FRAME_CHECKSUM_EN
    // Checksum covers LEN, CMD and payload, folded in as each byte is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (start_accept) begin
            csum_q <= '0;
        end else if (issue) begin
            case (state_q)
                ST_LEN:  csum_q <= csum_q ^ len_byte;
                ST_CMD:  csum_q <= csum_q ^ cmd_q;
                ST_DATA: csum_q <= csum_q ^ rd_data;
                default: csum_q <= csum_q;
            endcase
        end
    end
`endif

    always_comb begin
        tx_start = issue;
        busy     = (state_q != ST_IDLE) && (state_q != ST_FIN);
        done     = (state_q == ST_FIN);
        rd_en    = (state_q == ST_FETCH);
        rd_addr  = (state_q == ST_FETCH) ? idx_q[AW-1:0] : '0;
        tx_data  = '0;
        case (state_q)
            ST_SOF:  tx_data = FRAME_SOF;
            ST_LEN:  tx_data = len_byte;
            ST_CMD:  tx_data = cmd_q;
            ST_DATA: tx_data = waiting_q ? data_q : rd_data;
`ifdef MXV_FRAME_CHECKSUM_EN
            ST_CSUM: tx_data = csum_q;
`endif
            ST_EOF:  tx_data = FRAME_EOF;
            default: tx_data = '0;
        endcase
    end

endmodule

// File: tb/tb_mxv_resp_framer.sv
// Scoreboard bench for mxv_resp_framer: expected bytes/addresses/frame lengths are queued at
// stimulus time and consumed by an independent monitor. Honours MXV_FRAME_CHECKSUM_EN.
module tb_mxv_resp_framer;
    import mxv_resp_framer_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int AW      = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    cmd;
    logic [AW:0]   len;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = 8'h00;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_done = 1'b0;
    logic          busy;
    logic          done;

    logic [7:0] mem [MAX_LEN];
    logic [7:0] exp_bytes [$];
    int         exp_addr  [$];
    int         exp_len   [$];

    int assert_cnt  = 0;
    int fail_cnt    = 0;
    int issued_cnt  = 0;
    int frame_bytes = 0;
    int tx_delay    = 0;
    bit noise_en    = 1'b0;

    always #5 clk = ~clk;

    mxv_resp_framer #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd      (cmd),
        .len      (len),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy),
        .done     (done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Result buffer: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);
    end

    // UART TX model: checks tx_data stays put while a byte is on the wire, then pulses tx_done.
    always @(negedge clk) begin
        static bit         active    = 1'b0;
        static int         countdown = 0;
        static logic [7:0] held      = 8'h00;
        if (rst) begin
            active  = 1'b0;
            tx_done = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (active) begin
                checkOutput("tx_data_stable", tx_data, held);
                checkOutput("tx_start_in_wait", tx_start, 1'b0);
                countdown--;
                if (countdown <= 0) begin
                    tx_done = 1'b1;
                    active  = 1'b0;
                end
            end else if (tx_start) begin
                active    = 1'b1;
                held      = tx_data;
                countdown = (tx_delay > 0) ? tx_delay : int'($urandom_range(2, 12));
                if (noise_en && ($urandom_range(0, 1) == 1)) tx_done = 1'b1;
            end else if (noise_en && ($urandom_range(0, 5) == 0)) begin
                tx_done = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues a byte, reads, or ends a frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                issued_cnt++;
                frame_bytes++;
                checkOutput("busy_during_byte", busy, 1'b1);
                if (exp_bytes.size() == 0) checkOutput("unexpected_tx_start", tx_start, 1'b0);
                else checkOutput("tx_byte", tx_data, exp_bytes.pop_front());
            end
            if (rd_en) begin
                if (exp_addr.size() == 0) checkOutput("unexpected_rd_en", rd_en, 1'b0);
                else checkOutput("rd_addr", rd_addr, exp_addr.pop_front());
            end
            if (done) begin
                checkOutput("busy_at_done", busy, 1'b0);
                if (exp_len.size() == 0) checkOutput("unexpected_done", done, 1'b0);
                else checkOutput("frame_byte_count", frame_bytes, exp_len.pop_front());
                frame_bytes = 0;
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_start"}, tx_start, 1'b0);
        checkOutput({tag, "_tx_data"},  tx_data,  8'h00);
        checkOutput({tag, "_rd_en"},    rd_en,    1'b0);
        checkOutput({tag, "_rd_addr"},  rd_addr,  '0);
        checkOutput({tag, "_busy"},     busy,     1'b0);
        checkOutput({tag, "_done"},     done,     1'b0);
    endtask

    // Reference frame built straight from the frame format, not from the RTL state sequence.
    task automatic applyStimulus(input logic [7:0] c, input int l, input bit rand_mem);
        int         guard = 0;
        int         n;
        logic [7:0] sum;
        @(negedge clk);
        while (busy && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (busy) checkOutput("wait_not_busy", busy, 1'b0);
        if (rand_mem) foreach (mem[i]) mem[i] = 8'($urandom);
        n   = (l > MAX_LEN) ? MAX_LEN : l;
        sum = 8'(n + 1) ^ c;
        exp_bytes.push_back(FRAME_SOF);
        exp_bytes.push_back(8'(n + 1));
        exp_bytes.push_back(c);
        for (int i = 0; i < n; i++) begin
            exp_bytes.push_back(mem[i]);
            exp_addr.push_back(i);
            sum ^= mem[i];
        end
`ifdef MXV_FRAME_CHECKSUM_EN
        exp_bytes.push_back(sum);
        exp_len.push_back(n + 5);
`else
        exp_len.push_back(n + 4);
`endif
        exp_bytes.push_back(FRAME_EOF);
        start = 1'b1;
        cmd   = c;
        len   = (AW+1)'(l);
        @(negedge clk);
        start = 1'b0;
        cmd   = 8'($urandom);
        len   = (AW+1)'($urandom);
        checkOutput("sof_latency_tx_start", tx_start, 1'b1);
        checkOutput("sof_latency_busy", busy, 1'b1);
    endtask

    task automatic waitFramesDone();
        int guard = 0;
        while ((busy || exp_len.size() != 0) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (busy) checkOutput("frame_timeout_busy", busy, 1'b0);
        checkOutput("pending_frames", exp_len.size(), 0);
    endtask

    task automatic abortWithReset();
        rst = 1'b1;
        exp_bytes.delete();
        exp_addr.delete();
        exp_len.delete();
        frame_bytes = 0;
        @(negedge clk);
        checkResetValues("abort");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int guard;
        rst   = 1'b1;
        start = 1'b0;
        cmd   = 8'h00;
        len   = '0;
        foreach (mem[i]) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;

        // Directed: three-byte result, fixed UART latency.
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        tx_delay = 10;
        applyStimulus(CMD_READ_RESULT, 3, 1'b0);
        waitFramesDone();

        // Directed: empty payload, then clamped oversize request.
        applyStimulus(CMD_LOAD_VECTOR, 0, 1'b1);
        waitFramesDone();
        tx_delay = 3;
        applyStimulus(CMD_READ_RESULT, 12, 1'b1);
        waitFramesDone();

        // Start while busy plus tx_done noise (including in issue cycles) must change nothing.
        noise_en = 1'b1;
        tx_delay = 0;
        applyStimulus(CMD_LOAD_MATRIX, 5, 1'b1);
        repeat (7) @(negedge clk);
        start = 1'b1; cmd = CMD_MULTIPLY; len = 4'd2;
        @(negedge clk);
        start = 1'b0;
        waitFramesDone();
        noise_en = 1'b0;

        // Abort after the second payload byte is issued, then a clean frame.
        tx_delay = 4;
        base = issued_cnt;
        applyStimulus(CMD_MULTIPLY, 6, 1'b1);
        guard = 0;
        while ((issued_cnt - base) < 5 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("abort_point_reached", (issued_cnt - base) >= 5, 1'b1);
        abortWithReset();
        repeat (20) @(negedge clk);
        applyStimulus(CMD_READ_RESULT, 4, 1'b1);
        waitFramesDone();

`ifdef MXV_FRAME_CHECKSUM_EN
        mem[0] = 8'h0F; mem[1] = 8'hF0;
        applyStimulus(CMD_READ_RESULT, 2, 1'b0);
        waitFramesDone();
`endif

        // Random frames; several issued back-to-back so some starts land in FIN.
        for (int f = 0; f < 25; f++) begin
            tx_delay = ($urandom_range(0, 2) == 0) ? 1 : 0;
            noise_en = ($urandom_range(0, 1) == 1);
            applyStimulus(8'($urandom_range(1, 4)), int'($urandom_range(0, 15)), 1'b1);
            if ($urandom_range(0, 2) == 0) waitFramesDone();
        end
        waitFramesDone();
        repeat (10) @(negedge clk);
        checkOutput("leftover_bytes", exp_bytes.size(), 0);
        checkOutput("leftover_reads", exp_addr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
